// File: rtl/vol_key_pio_in.sv
// Avalon-MM input port: synchronizes, debounces and edge-captures board keys, raising a maskable level irq.
// Define VOL_KEY_PIO_IN_DEBOUNCE_EN to include the per-bit debounce counters; otherwise stable follows the synchronizer.
module vol_key_pio_in #(
    parameter int   WIDTH           = 4,
    parameter int   DEBOUNCE_CYCLES = 50000,
    parameter logic IDLE_LEVEL      = 1'b1,
    parameter int   EDGE_TYPE       = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    localparam logic [WIDTH-1:0] IDLE_VEC = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_stableD;
    logic [WIDTH-1:0] r_irqMask;
    logic [WIDTH-1:0] r_edgeCapture;
    logic [WIDTH-1:0] w_stable;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clearMask;
    logic             w_write;
    logic             w_unusedWriteBits;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= IDLE_VEC;
            r_sync2 <= IDLE_VEC;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

`ifdef VOL_KEY_PIO_IN_DEBOUNCE_EN
    localparam int             CNT_W    = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]            r_stable;
    logic [WIDTH-1:0][CNT_W-1:0] r_count;

    // A bit's level is accepted only after it has differed from stable for DEBOUNCE_CYCLES straight cycles.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stable <= IDLE_VEC;
            r_count  <= '0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                if (r_sync2[i] == r_stable[i]) begin
                    r_count[i] <= '0;
                end else if (r_count[i] == CNT_TERM) begin
                    r_stable[i] <= r_sync2[i];
                    r_count[i]  <= '0;
                end else begin
                    r_count[i] <= r_count[i] + CNT_W'(1);
                end
            end
        end
    end

    assign w_stable = r_stable;
`else
    // Without debouncing the second synchronizer stage is the stable level itself.
    assign w_stable = r_sync2;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stableD <= IDLE_VEC;
        end else begin
            r_stableD <= w_stable;
        end
    end

    always_comb begin
        w_edge = '0;
        case (EDGE_TYPE)
            0:       w_edge = ~r_stableD & w_stable;
            1:       w_edge = r_stableD & ~w_stable;
            default: w_edge = r_stableD ^ w_stable;
        endcase
    end

    assign w_write           = chipselect && !write_n;
    assign w_clearMask       = (w_write && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
    assign w_unusedWriteBits = ^writedata;

    // A new edge is OR-ed in after the W1C clear so a same-cycle set always survives.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_irqMask     <= '0;
            r_edgeCapture <= '0;
        end else begin
            r_edgeCapture <= (r_edgeCapture & ~w_clearMask) | w_edge;
            if (w_write && address == 2'd2) begin
                r_irqMask <= writedata[WIDTH-1:0];
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0:    readdata = 32'(w_stable);
            2'd2:    readdata = 32'(r_irqMask);
            2'd3:    readdata = 32'(r_edgeCapture);
            default: readdata = '0;
        endcase
    end

    assign irq = |(r_edgeCapture & r_irqMask);

endmodule

// File: tb/tb_vol_key_pio_in.sv
// Scoreboard bench for vol_key_pio_in: a window-based key model predicts every read; a monitor compares.
// Directed scenarios follow VOL_KEY_PIO_IN_DEBOUNCE_EN, then a randomized phase runs in either build.
module tb_vol_key_pio_in;

    localparam int WIDTH = 4;
    localparam int DEB   = 8;
    localparam int EDGE  = 1;
`ifdef VOL_KEY_PIO_IN_DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  address = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n = 1'b1;
    logic [31:0] writedata = 32'd0;
    logic [31:0] readdata;
    logic [3:0]  in_port = 4'hF;
    logic        irq;

    always #5 clk = ~clk;

    vol_key_pio_in #(
        .WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .IDLE_LEVEL(1'b1), .EDGE_TYPE(EDGE)
    ) dut (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    // Reference model: a key level is accepted once the last DEB synchronized samples all disagree with it.
    logic [3:0] mStable, mStableD, mMask, mCap;
    logic [3:0] hist[$];

    function automatic logic [3:0] nextStable(input logic [3:0] cur);
        logic [3:0] n;
        bit         allDiff;
        n = cur;
        if (!DEB_ON) return hist[DEB];
        for (int b = 0; b < WIDTH; b++) begin
            allDiff = 1'b1;
            for (int k = 0; k < DEB; k++) if (hist[k][b] == cur[b]) allDiff = 1'b0;
            if (allDiff) n[b] = ~cur[b];
        end
        return n;
    endfunction

    function automatic logic [3:0] edgesOf(input logic [3:0] prev, input logic [3:0] cur);
        case (EDGE)
            0:       return ~prev & cur;
            1:       return prev & ~cur;
            default: return prev ^ cur;
        endcase
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mStable  <= 4'hF;
            mStableD <= 4'hF;
            mMask    <= 4'h0;
            mCap     <= 4'h0;
            hist.delete();
            for (int i = 0; i < DEB + 2; i++) hist.push_back(4'hF);
        end else begin
            hist.push_back(in_port);
            void'(hist.pop_front());
            mCap <= (mCap & ~((chipselect && !write_n && address == 2'd3) ? writedata[3:0] : 4'h0))
                    | edgesOf(mStableD, mStable);
            if (chipselect && !write_n && address == 2'd2) mMask <= writedata[3:0];
            mStableD <= mStable;
            mStable  <= nextStable(mStable);
        end
    end

    function automatic logic [31:0] modelRead(input logic [1:0] a);
        case (a)
            2'd0:    return {28'd0, mStable};
            2'd2:    return {28'd0, mMask};
            2'd3:    return {28'd0, mCap};
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [31:0] rd;
        logic        irqExp;
        string       name;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    // One bus cycle: drive at the falling edge and queue what the read must show this cycle.
    task automatic applyStimulus(input logic [3:0] inp, input logic [1:0] a, input bit wr,
                                 input logic [31:0] wd, input bit useConst,
                                 input logic [31:0] cRd, input logic cIrq, input string tag);
        exp_t e;
        @(negedge clk);
        in_port    = inp;
        address    = a;
        chipselect = 1'b1;
        write_n    = ~wr;
        writedata  = wd;
        e.rd     = useConst ? cRd : modelRead(a);
        e.irqExp = useConst ? cIrq : |(mCap & mMask);
        e.name   = tag;
        sbq.push_back(e);
    endtask

    task automatic modelCycles(input logic [3:0] inp, input int n, input string tag);
        for (int i = 0; i < n; i++) applyStimulus(inp, 2'(i), 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, tag);
    endtask

    task automatic checkOutput(input exp_t e);
        checks++;
        if (readdata !== e.rd) begin
            errors++;
            $display("[TB] FAIL %s readdata: got %h want %h (t=%0t)", e.name, readdata, e.rd, $time);
        end
        checks++;
        if (irq !== e.irqExp) begin
            errors++;
            $display("[TB] FAIL %s irq: got %b want %b (t=%0t)", e.name, irq, e.irqExp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            while (sbq.size() > 0) begin
                e = sbq.pop_front();
                checkOutput(e);
            end
        end
    end

    task automatic doReset(input logic [3:0] inp);
        @(negedge clk);
        reset_n    = 1'b0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        in_port    = inp;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic resetChecks();
        applyStimulus(4'hF, 2'd0, 1'b0, 32'd0, 1'b1, 32'h0000000F, 1'b0, "reset_data");
        applyStimulus(4'hF, 2'd1, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "reset_rsvd");
        applyStimulus(4'hF, 2'd2, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "reset_mask");
        applyStimulus(4'hF, 2'd3, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "reset_cap");
    endtask

    initial begin
        logic [3:0]  rin;
        logic [31:0] rwd;
        int          hold;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        resetChecks();
`ifdef VOL_KEY_PIO_IN_DEBOUNCE_EN
        // Glitch shorter than the debounce window.
        modelCycles(4'hE, 5, "glitch_low");
        modelCycles(4'hF, 12, "glitch_high");
        applyStimulus(4'hF, 2'd0, 1'b0, 32'd0, 1'b1, 32'hF, 1'b0, "glitch_data");
        applyStimulus(4'hF, 2'd3, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "glitch_cap");
        // Clean press with bit0 masked in.
        applyStimulus(4'hF, 2'd2, 1'b1, 32'h1, 1'b0, 32'd0, 1'b0, "mask_wr1");
        modelCycles(4'hE, 9, "press_wait");
        applyStimulus(4'hE, 2'd0, 1'b0, 32'd0, 1'b1, 32'hF, 1'b0, "press_data_e9");
        applyStimulus(4'hE, 2'd0, 1'b0, 32'd0, 1'b1, 32'hE, 1'b0, "press_data_e10");
        applyStimulus(4'hE, 2'd3, 1'b0, 32'd0, 1'b1, 32'h1, 1'b1, "press_cap_e11");
        modelCycles(4'hF, 14, "release");
        applyStimulus(4'hF, 2'd3, 1'b0, 32'd0, 1'b1, 32'h1, 1'b1, "release_nocap");
        // W1C clear, then a clear that collides with a new capture.
        applyStimulus(4'hF, 2'd3, 1'b1, 32'h1, 1'b0, 32'd0, 1'b0, "w1c_wr");
        applyStimulus(4'hF, 2'd3, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "w1c_cleared");
        for (int i = 0; i <= 10; i++) applyStimulus(4'hE, 2'd3, 1'b1, 32'h1, 1'b0, 32'd0, 1'b0, "collide_wr");
        applyStimulus(4'hE, 2'd3, 1'b0, 32'd0, 1'b1, 32'h1, 1'b1, "collide_setwins");
        // Masked-out capture, then late mask enable, then ignored writes.
        modelCycles(4'hF, 12, "mask_release");
        applyStimulus(4'hF, 2'd3, 1'b1, 32'hF, 1'b0, 32'd0, 1'b0, "mask_clrall");
        applyStimulus(4'hF, 2'd2, 1'b1, 32'h0, 1'b0, 32'd0, 1'b0, "mask_wr0");
        modelCycles(4'hB, 12, "bit2_press");
        applyStimulus(4'hB, 2'd3, 1'b0, 32'd0, 1'b1, 32'h4, 1'b0, "bit2_cap_noirq");
        applyStimulus(4'hB, 2'd2, 1'b1, 32'h4, 1'b0, 32'd0, 1'b0, "mask_wr4");
        applyStimulus(4'hB, 2'd2, 1'b0, 32'd0, 1'b1, 32'h4, 1'b1, "mask_irq_next");
        applyStimulus(4'hB, 2'd1, 1'b1, 32'hFFFFFFFF, 1'b0, 32'd0, 1'b0, "wr_rsvd");
        applyStimulus(4'hB, 2'd0, 1'b1, 32'h0, 1'b0, 32'd0, 1'b0, "wr_data");
        applyStimulus(4'hB, 2'd3, 1'b0, 32'd0, 1'b1, 32'h4, 1'b1, "ignored_cap");
        applyStimulus(4'hB, 2'd0, 1'b0, 32'd0, 1'b1, 32'hB, 1'b1, "ignored_data");
        applyStimulus(4'hB, 2'd1, 1'b0, 32'd0, 1'b1, 32'h0, 1'b1, "ignored_rsvd");
        // Reset in the middle of a debounce count.
        modelCycles(4'h7, 6, "abort_press");
        doReset(4'hF);
        modelCycles(4'hF, 15, "post_abort");
        applyStimulus(4'hF, 2'd3, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "abort_nocap");
        applyStimulus(4'hF, 2'd0, 1'b0, 32'd0, 1'b1, 32'hF, 1'b0, "abort_data");
`else
        // Without debouncing a held press captures three edges after the change.
        modelCycles(4'h7, 2, "nodeb_press");
        applyStimulus(4'h7, 2'd3, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "nodeb_cap_e2");
        applyStimulus(4'h7, 2'd3, 1'b0, 32'd0, 1'b1, 32'h8, 1'b0, "nodeb_cap_e3");
        modelCycles(4'hF, 4, "nodeb_release");
        applyStimulus(4'hF, 2'd3, 1'b1, 32'hF, 1'b0, 32'd0, 1'b0, "nodeb_clr");
        applyStimulus(4'hF, 2'd3, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, "nodeb_cleared");
        applyStimulus(4'h7, 2'd3, 1'b0, 32'd0, 1'b0, 32'd0, 1'b0, "nodeb_pulse");
        modelCycles(4'hF, 4, "nodeb_after_pulse");
        applyStimulus(4'hF, 2'd3, 1'b0, 32'd0, 1'b1, 32'h8, 1'b0, "nodeb_pulse_cap");
        applyStimulus(4'hF, 2'd2, 1'b1, 32'h8, 1'b0, 32'd0, 1'b0, "nodeb_mask");
        applyStimulus(4'hF, 2'd2, 1'b0, 32'd0, 1'b1, 32'h8, 1'b1, "nodeb_irq");
`endif
        // Randomized key activity and bus traffic against the model.
        for (int blk = 0; blk < 80; blk++) begin
            rin  = 4'($urandom);
            hold = $urandom_range(1, 12);
            for (int i = 0; i < hold; i++) begin
                rwd = $urandom;
                applyStimulus(rin, 2'($urandom), ($urandom_range(0, 5) == 0), rwd,
                              1'b0, 32'd0, 1'b0, "random");
            end
        end
        @(negedge clk);
        chipselect = 1'b0;
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vol_key_pio_in.md
# vol_key_pio_in

Avalon-MM slave input port that brings push-button/switch levels from the DE1 board into the HPS register map. It is the read-direction counterpart of the volume-control output port on the same lightweight bridge. It synchronizes and debounces each input bit, captures edges into a sticky register, and raises a maskable level interrupt so software can step volume up or down on key presses.

## Interface
- WIDTH, 4: number of input bits (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required before a level change is accepted (1 ms at 50 MHz); must be >= 2.
- IDLE_LEVEL, 1'b1: released level of every input bit; applied to all bits at reset.
- EDGE_TYPE, 1: 0 = rising, 1 = falling, 2 = any edge sets capture.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  word address within the slave.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address; unused upper bits 0.
- in_port  in  WIDTH  raw asynchronous board inputs.
- irq  out  1  level interrupt, active high.

## Operation
- Register map (word addresses):
  - 0 DATA (RO): debounced level, bits [WIDTH-1:0]. Writes ignored.
  - 1: reserved, reads 0, writes ignored.
  - 2 IRQ_MASK (RW): bits [WIDTH-1:0]; reset 0.
  - 3 EDGE_CAPTURE (R/W1C): bit set on a qualifying edge; a write with writedata[i]=1 clears bit i, 0 leaves it.
- Write qualified by chipselect && !write_n; zero wait states; reads have no side effects.
- Per bit: 2-flop synchronizer, then debouncer, then edge detector.
- Debouncer: counter of width clog2(DEBOUNCE_CYCLES).
  - Clears whenever sync == stable.
  - Otherwise increments.
  - When the counter equals DEBOUNCE_CYCLES-1 while sync != stable: stable <= sync and the counter clears.
  - Any glitch back to stable before terminal count restarts the count.
- Edge detect compares stable with stable_d (stable delayed one cycle):
  - Rising: !stable_d & stable.
  - Falling: stable_d & !stable.
  - Any: XOR of the two.
- irq = |(EDGE_CAPTURE & IRQ_MASK), combinational from registers.

## Timing
- Reset values:
  - Sync flops, stable, stable_d: IDLE_LEVEL.
  - Counters: 0.
  - IRQ_MASK: 0. EDGE_CAPTURE: 0.
  - irq: 0. readdata at address 0: IDLE_LEVEL replicated.
- Reset deasserted with inputs at idle produces no edge.
- Latency, in_port change held steady (debounce on):
  - Sampled by sync1 at edge 1; sync2 at edge 2.
  - stable updates at edge 2+DEBOUNCE_CYCLES.
  - EDGE_CAPTURE bit sets at edge 3+DEBOUNCE_CYCLES.
  - irq rises combinationally in that same cycle if masked in.
- W1C clear takes effect at the write's clock edge; irq falls the same cycle.
- Simultaneous set and W1C clear on the same bit in the same cycle: set wins (bit stays 1).
- Mask write takes effect on the following cycle for irq. Enabling the mask on an already-captured bit raises irq immediately; no edge is lost.
- Reset mid-debounce: count is discarded; stable returns to IDLE_LEVEL; no edge is reported for the aborted change.

## Configuration
- VOL_KEY_PIO_IN_DEBOUNCE_EN defined: per-bit debounce counters present as described above.
- Not defined: counters removed; stable <= sync2 each cycle. Capture latency becomes 3 edges after the input change. DEBOUNCE_CYCLES is ignored. Register map unchanged.

## Test plan
All scenarios use WIDTH=4, DEBOUNCE_CYCLES=8, EDGE_TYPE=1, with the macro defined unless stated otherwise.

- Reset with in_port=4'hF:
  - DATA reads 0x0000000F; IRQ_MASK and EDGE_CAPTURE read 0; irq=0.
- Glitch rejection:
  - Drive bit0 low for 5 cycles, then high.
  - Required: DATA stays 0xF; EDGE_CAPTURE stays 0.
- Clean press:
  - Write IRQ_MASK=0x1; hold bit0 low.
  - Required: DATA=0xE at edge 10; EDGE_CAPTURE=0x1 and irq=1 at edge 11.
  - Releasing bit0 sets no capture (falling-only).
- W1C and collision:
  - Write EDGE_CAPTURE=0x1; capture clears and irq falls the same cycle.
  - Repeat the write timed to the cycle a new falling edge on bit0 sets the capture: bit remains 1.
- Mask behaviour:
  - Capture bit2 with IRQ_MASK=0: irq=0.
  - Write IRQ_MASK=0x4: irq=1 the next cycle.
  - Write address 1 and address 0: no register changes.
- Macro undefined:
  - Bit3 held low: EDGE_CAPTURE=0x8 at edge 3.
  - A 1-cycle low pulse on bit3 sets capture.
